countdown_timer: RTL and testbench

Programmable down-counting timer with prescaler, optional auto-reload and a level interrupt with acknowledge handshake. It counts down where the existing up counter counts up. It raises an expiry event towards the 16-bit MIPS core's interrupt logic. The core programs and acknowledges it through simple strobe inputs.

---
 rtl/countdown_timer.sv | 122 ++++++++++++
 tb/tb_countdown_timer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Programmable down-counting timer with prescaler, optional auto-reload and a
// sticky level interrupt (with overrun flag) cleared by an acknowledge strobe.
module countdown_timer #(
    parameter int WIDTH      = 16,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_value,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  auto_reload,
    input  logic                  irq_ack,
    output logic [WIDTH-1:0]      count,
    output logic                  busy,
    output logic                  irq,
    output logic                  overrun
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state, state_next;
    logic [WIDTH-1:0]      count_next;
    logic [WIDTH-1:0]      reload_reg, reload_next;
    logic [PRESCALE_W-1:0] pcnt, pcnt_next;
    logic                  tick;
    logic                  expiry;
    logic                  irq_next;
    logic                  overrun_next;

    // pcnt is free-running modulo 2^PRESCALE_W, so a prescale lowered below
    // the current pcnt simply waits for the wrap before the next tick.
    assign tick = (pcnt == prescale);

    // Command priority per cycle: stop > load > start > tick.
    always_comb begin
        state_next  = state;
        count_next  = count;
        reload_next = reload_reg;
        pcnt_next   = pcnt;
        expiry      = 1'b0;

        case (state)
            IDLE: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (load) begin
                    reload_next = load_value;
                    count_next  = load_value;
                end else if (start && (count != '0)) begin
                    state_next = RUN;
                    pcnt_next  = '0;
                end
            end

            RUN: begin
                if (stop) begin
                    state_next = IDLE;
                    pcnt_next  = '0;
                end else if (load) begin
                    reload_next = load_value;
                    count_next  = load_value;
                    pcnt_next   = '0;
                    state_next  = (load_value != '0) ? RUN : IDLE;
                end else if (tick) begin
                    pcnt_next = '0;
                    if (count == WIDTH'(1)) begin
                        expiry = 1'b1;
                        if (auto_reload && (reload_reg != '0)) begin
                            count_next = reload_reg;
                        end else begin
                            count_next = '0;
                            state_next = IDLE;
                        end
                    end else if (count != '0) begin
                        count_next = count - WIDTH'(1);
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    pcnt_next = pcnt + PRESCALE_W'(1);
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // An expiry wins over a same-cycle acknowledge; overrun needs irq already pending.
    always_comb begin
        irq_next     = expiry | (irq & ~irq_ack);
        overrun_next = (expiry & irq & ~irq_ack) | (overrun & ~irq_ack);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= '0;
            reload_reg <= '0;
            pcnt       <= '0;
            irq        <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_next;
            count      <= count_next;
            reload_reg <= reload_next;
            pcnt       <= pcnt_next;
            irq        <= irq_next;
            overrun    <= overrun_next;
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: driver pushes hand-computed expected
// {count,busy,irq,overrun} per cycle; a negedge monitor pops and compares.
module tb_countdown_timer;

    localparam int WIDTH      = 16;
    localparam int PRESCALE_W = 4;
    localparam int W          = WIDTH + 3;

    logic                  clk;
    logic                  rst_n;
    logic                  load;
    logic [WIDTH-1:0]      load_value;
    logic [PRESCALE_W-1:0] prescale;
    logic                  start;
    logic                  stop;
    logic                  auto_reload;
    logic                  irq_ack;
    logic [WIDTH-1:0]      count;
    logic                  busy;
    logic                  irq;
    logic                  overrun;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           checks;
    int           failures;

    countdown_timer #(
        .WIDTH      (WIDTH),
        .PRESCALE_W (PRESCALE_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .load_value  (load_value),
        .prescale    (prescale),
        .start       (start),
        .stop        (stop),
        .auto_reload (auto_reload),
        .irq_ack     (irq_ack),
        .count       (count),
        .busy        (busy),
        .irq         (irq),
        .overrun     (overrun)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic compare(input string nm, input logic [W-1:0] exp_v);
        logic [W-1:0] act;
        act = {count, busy, irq, overrun};
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got count=%0d busy=%0b irq=%0b overrun=%0b, expected count=%0d busy=%0b irq=%0b overrun=%0b",
                     nm, act[W-1:3], act[2], act[1], act[0],
                     exp_v[W-1:3], exp_v[2], exp_v[1], exp_v[0]);
        end
    endtask

    // monitor: pops one expected word per cycle, sampled on the falling edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            compare(name_q.pop_front(), exp_q.pop_front());
        end
    end

    // driver: one cycle of inputs plus the outputs expected after the next rising edge
    task automatic cyc(input logic ld, input logic [WIDTH-1:0] lv,
                       input logic [PRESCALE_W-1:0] ps, input logic st,
                       input logic sp, input logic ar, input logic ack,
                       input logic [WIDTH-1:0] ec, input logic eb,
                       input logic ei, input logic eo, input string nm);
        @(negedge clk);
        #1;
        load        = ld;
        load_value  = lv;
        prescale    = ps;
        start       = st;
        stop        = sp;
        auto_reload = ar;
        irq_ack     = ack;
        exp_q.push_back({ec, eb, ei, eo});
        name_q.push_back(nm);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        load        = 1'b0;
        load_value  = '0;
        prescale    = '0;
        start       = 1'b0;
        stop        = 1'b0;
        auto_reload = 1'b0;
        irq_ack     = 1'b0;
        repeat (2) @(negedge clk);
        compare("reset_initial", {16'd0, 3'b000});
        #1 rst_n = 1'b1;

        // asynchronous reset in RUN with count=5
        cyc(1, 16'd5, 4'd15, 0, 0, 0, 0, 16'd5, 0, 0, 0, "rst_load5");
        cyc(0, 16'd0, 4'd15, 1, 0, 0, 0, 16'd5, 1, 0, 0, "rst_start");
        cyc(0, 16'd0, 4'd15, 0, 0, 0, 0, 16'd5, 1, 0, 0, "rst_running");
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1 compare("reset_async", {16'd0, 3'b000});
        @(negedge clk);
        #1 rst_n = 1'b1;
        cyc(0, 16'd0, 4'd0, 1, 0, 0, 0, 16'd0, 0, 0, 0, "rst_start_ignored");
        cyc(0, 16'd0, 4'd0, 0, 0, 0, 0, 16'd0, 0, 0, 0, "rst_still_idle");

        // one-shot, prescale 0
        cyc(1, 16'd3, 4'd0, 0, 0, 0, 0, 16'd3, 0, 0, 0, "os_load3");
        cyc(0, 16'd0, 4'd0, 1, 0, 0, 0, 16'd3, 1, 0, 0, "os_start");
        cyc(0, 16'd0, 4'd0, 0, 0, 0, 0, 16'd2, 1, 0, 0, "os_cnt2");
        cyc(0, 16'd0, 4'd0, 0, 0, 0, 0, 16'd1, 1, 0, 0, "os_cnt1");
        cyc(0, 16'd0, 4'd0, 0, 0, 0, 0, 16'd0, 0, 1, 0, "os_expire");
        cyc(0, 16'd0, 4'd0, 0, 0, 0, 1, 16'd0, 0, 0, 0, "os_ack");

        // prescaled, prescale 3: decrements 4 and 8 cycles after start
        cyc(1, 16'd2, 4'd3, 0, 0, 0, 0, 16'd2, 0, 0, 0, "ps_load2");
        cyc(0, 16'd0, 4'd3, 1, 0, 0, 0, 16'd2, 1, 0, 0, "ps_start");
        for (int i = 1; i <= 3; i++)
            cyc(0, 16'd0, 4'd3, 0, 0, 0, 0, 16'd2, 1, 0, 0, "ps_wait_a");
        cyc(0, 16'd0, 4'd3, 0, 0, 0, 0, 16'd1, 1, 0, 0, "ps_dec4");
        for (int i = 5; i <= 7; i++)
            cyc(0, 16'd0, 4'd3, 0, 0, 0, 0, 16'd1, 1, 0, 0, "ps_wait_b");
        cyc(0, 16'd0, 4'd3, 0, 0, 0, 0, 16'd0, 0, 1, 0, "ps_expire8");
        cyc(0, 16'd0, 4'd3, 0, 0, 0, 1, 16'd0, 0, 0, 0, "ps_ack");

        // start with count==0 is ignored
        cyc(0, 16'd0, 4'd0, 1, 0, 0, 0, 16'd0, 0, 0, 0, "zero_start");

        // auto-reload and overrun
        cyc(1, 16'd2, 4'd0, 0, 0, 1, 0, 16'd2, 0, 0, 0, "ar_load2");
        cyc(0, 16'd0, 4'd0, 1, 0, 1, 0, 16'd2, 1, 0, 0, "ar_start");
        cyc(0, 16'd0, 4'd0, 0, 0, 1, 0, 16'd1, 1, 0, 0, "ar_c1");
        cyc(0, 16'd0, 4'd0, 0, 0, 1, 0, 16'd2, 1, 1, 0, "ar_exp1");
        cyc(0, 16'd0, 4'd0, 0, 0, 1, 0, 16'd1, 1, 1, 0, "ar_c3");
        cyc(0, 16'd0, 4'd0, 0, 0, 1, 0, 16'd2, 1, 1, 1, "ar_overrun");
        cyc(0, 16'd0, 4'd0, 0, 0, 1, 0, 16'd1, 1, 1, 1, "ar_c5");
        cyc(0, 16'd0, 4'd0, 0, 0, 1, 1, 16'd2, 1, 1, 0, "ar_ack_on_expiry");
        cyc(0, 16'd0, 4'd0, 0, 0, 1, 0, 16'd1, 1, 1, 0, "ar_c7");
        cyc(0, 16'd0, 4'd0, 0, 1, 0, 0, 16'd1, 0, 1, 0, "ar_stop");
        cyc(0, 16'd0, 4'd0, 0, 0, 0, 1, 16'd1, 0, 0, 0, "ar_final_ack");

        // priority: stop over a coinciding expiry tick
        cyc(0, 16'd0, 4'd0, 1, 0, 0, 0, 16'd1, 1, 0, 0, "pri_start1");
        cyc(0, 16'd0, 4'd0, 0, 1, 0, 0, 16'd1, 0, 0, 0, "pri_stop_hold");
        // priority: load over a coinciding expiry tick
        cyc(0, 16'd0, 4'd0, 1, 0, 0, 0, 16'd1, 1, 0, 0, "pri_start2");
        cyc(1, 16'd7, 4'd0, 0, 0, 0, 0, 16'd7, 1, 0, 0, "pri_load7");
        cyc(0, 16'd0, 4'd0, 0, 0, 0, 0, 16'd6, 1, 0, 0, "pri_cnt6");
        cyc(1, 16'd0, 4'd0, 0, 0, 0, 0, 16'd0, 0, 0, 0, "load0_in_run");
        cyc(0, 16'd0, 4'd0, 0, 0, 0, 0, 16'd0, 0, 0, 0, "load0_idle");

        // load+start together in IDLE: load wins, start dropped
        cyc(1, 16'd4, 4'd0, 1, 0, 0, 0, 16'd4, 0, 0, 0, "ldst_load");
        cyc(0, 16'd0, 4'd0, 0, 0, 0, 0, 16'd4, 0, 0, 0, "ldst_idle");

        // prescale lowered below pcnt: pcnt wraps before the next tick
        cyc(1, 16'd1, 4'd5, 0, 0, 0, 0, 16'd1, 0, 0, 0, "wrap_load1");
        cyc(0, 16'd0, 4'd5, 1, 0, 0, 0, 16'd1, 1, 0, 0, "wrap_start");
        for (int i = 1; i <= 3; i++)
            cyc(0, 16'd0, 4'd5, 0, 0, 0, 0, 16'd1, 1, 0, 0, "wrap_pre");
        for (int i = 4; i <= 17; i++)
            cyc(0, 16'd0, 4'd1, 0, 0, 0, 0, 16'd1, 1, 0, 0, "wrap_spin");
        cyc(0, 16'd0, 4'd1, 0, 0, 0, 0, 16'd0, 0, 1, 0, "wrap_expire");
        cyc(0, 16'd0, 4'd1, 0, 0, 0, 1, 16'd0, 0, 0, 0, "wrap_ack");

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain_timeout: %0d expected entries left, required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
